matrix_line_ctrl: RTL and testbench

//  Sequencer for the two line-buffer RAMs of the 3x3 matrix generator in the VIP path.
//  - Drives read/write of both RAMs from an incoming pixel stream.
//  - Cascades line N-1 into line N-2.
//  - Emits three vertically aligned taps (row0 = current, row1 = N-1, row2 = N-2).
//  - Masks rows not yet filled in the frame.

---
 rtl/vip_matrix_pkg.sv | 25 ++
 rtl/vip_dly_pipe.sv | 35 +++
 rtl/matrix_line_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_matrix_line_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vip_matrix_pkg.sv
// vip_matrix_pkg
//   Shared definitions for the 3x3 matrix generator line-buffer control.
//   - state_t      : line sequencer FSM encoding
//   - PIPE_LAT     : input-to-output latency of the window taps
//   - RAM_RD_LAT   : line-buffer RAM read latency (read edge to valid q)
//   - line_cnt_inc : saturating line counter increment (caps at 2)
package vip_matrix_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_LINE = 2'd2
    } state_t;

    localparam int PIPE_LAT     = 3;
    localparam int RAM_RD_LAT   = 2;
    localparam logic [1:0] LINE_CNT_MAX = 2'd2;

    // Only "at least one" and "at least two" previous lines matter,
    // so the count stops at 2.
    function automatic logic [1:0] line_cnt_inc(input logic [1:0] cnt);
        return (cnt >= LINE_CNT_MAX) ? LINE_CNT_MAX : cnt + 2'd1;
    endfunction

endpackage

// File: rtl/vip_dly_pipe.sv
// vip_dly_pipe
//   Parameterised shift-register delay line with asynchronous reset.
// Ports
//   clock : clock
//   reset : asynchronous, active-high; clears every stage
//   d     : input word  [WIDTH-1:0]
//   q     : d delayed by DEPTH clocks
module vip_dly_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/matrix_line_ctrl.sv
// matrix_line_ctrl
//   Sequencer for the two line-buffer RAMs of the 3x3 matrix generator.
//   RAM1 holds line N-1, RAM2 holds line N-2; each pixel read from RAM1 is
//   cascaded into RAM2 at the same address. Emits three vertically aligned
//   taps, masking rows that have not been filled yet in the current frame.
// Ports
//   clock          : single clock for controller and both RAMs
//   reset          : asynchronous, active-high
//   in_vs          : frame-start pulse (1 cycle)
//   in_de          : pixel valid, contiguous run per line
//   in_data        : pixel [DATA_W:0]
//   ram_rden       : read enable, both RAMs
//   ram_rd_address : read address, both RAMs [ADDR_W:0]
//   ram_wren       : write enable, both RAMs
//   ram_wr_address : write address, both RAMs [ADDR_W:0]
//   ram1_data      : write data RAM1 (current pixel, becomes line N-1)
//   ram2_data      : write data RAM2 (old RAM1 content, becomes line N-2)
//   ram1_q/ram2_q  : RAM read data, 2-cycle latency
//   out_vs/out_de  : in_vs/in_de delayed 3 cycles
//   out_row0/1/2   : current / N-1 / N-2 column taps
//   col_ovf        : sticky line-too-long flag, cleared by in_vs or reset
module matrix_line_ctrl
    import vip_matrix_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_vs,
    input  logic              in_de,
    input  logic [DATA_W:0]   in_data,
    output logic              ram_rden,
    output logic [ADDR_W:0]   ram_rd_address,
    output logic              ram_wren,
    output logic [ADDR_W:0]   ram_wr_address,
    output logic [DATA_W:0]   ram1_data,
    output logic [DATA_W:0]   ram2_data,
    input  logic [DATA_W:0]   ram1_q,
    input  logic [DATA_W:0]   ram2_q,
    output logic              out_vs,
    output logic              out_de,
    output logic [DATA_W:0]   out_row0,
    output logic [DATA_W:0]   out_row1,
    output logic [DATA_W:0]   out_row2,
    output logic              col_ovf
);

    localparam logic [ADDR_W:0] COL_MAX = '1;

    state_t          state;
    state_t          state_nxt;
    logic [ADDR_W:0] col;
    logic            col_full;
    logic [1:0]      line_cnt;

    logic            accept;
    logic            frame_clr;
    logic            line_end;

    logic            wr_ok;
    logic            v1;
    logic            v2;

    logic            vs_d2;
    logic            de_d2;
    logic            wr_d2;
    logic            v1_d2;
    logic            v2_d2;
    logic [ADDR_W:0] col_d2;
    logic [DATA_W:0] pix_d2;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_vs) state_nxt = S_GAP;
            S_GAP:   if (in_de) state_nxt = S_LINE;
            S_LINE:  if (in_vs || !in_de) state_nxt = S_GAP;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        accept    = 1'b0;
        frame_clr = 1'b0;
        line_end  = 1'b0;
        case (state)
            S_IDLE: begin
                frame_clr = in_vs;
            end
            S_GAP: begin
                accept    = in_de;
                frame_clr = in_vs;
            end
            S_LINE: begin
                accept    = in_de;
                frame_clr = in_vs;
                line_end  = !in_de && !in_vs;
            end
            default: ;
        endcase
    end

    // ---------------- column / line counters ----------------
    // col_full marks that the last RAM address has been used; col itself
    // stays at COL_MAX so it never wraps onto live data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col      <= '0;
            col_full <= 1'b0;
            line_cnt <= '0;
            col_ovf  <= 1'b0;
        end else if (frame_clr) begin
            col      <= '0;
            col_full <= 1'b0;
            line_cnt <= '0;
            col_ovf  <= 1'b0;
        end else if (line_end) begin
            col      <= '0;
            col_full <= 1'b0;
            line_cnt <= line_cnt_inc(line_cnt);
        end else if (accept) begin
            if (col_full) begin
                col_ovf <= 1'b1;
            end else if (col == COL_MAX) begin
                col_full <= 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // ---------------- read side ----------------
    assign ram_rden       = accept;
    assign ram_rd_address = col;

    // Pixels past the RAM depth are neither written nor allowed to show
    // RAM contents on the upper rows.
    assign wr_ok = accept & ~col_full;
    assign v1    = wr_ok & (line_cnt != 2'd0);
    assign v2    = wr_ok & (line_cnt >= 2'd2);

    // ---------------- delay pipes aligned to RAM read latency ----------------
    vip_dly_pipe #(.WIDTH(5), .DEPTH(RAM_RD_LAT)) u_flag_pipe (
        .clock (clock),
        .reset (reset),
        .d     ({in_vs, accept, wr_ok, v1, v2}),
        .q     ({vs_d2, de_d2, wr_d2, v1_d2, v2_d2})
    );

    vip_dly_pipe #(.WIDTH(ADDR_W + 1), .DEPTH(RAM_RD_LAT)) u_col_pipe (
        .clock (clock),
        .reset (reset),
        .d     (col),
        .q     (col_d2)
    );

    vip_dly_pipe #(.WIDTH(DATA_W + 1), .DEPTH(RAM_RD_LAT)) u_pix_pipe (
        .clock (clock),
        .reset (reset),
        .d     (in_data),
        .q     (pix_d2)
    );

    // ---------------- write side ----------------
    // RAM2 takes the value just read from RAM1 at the same address, which
    // shifts line N-1 down to N-2 as line N overwrites RAM1.
    assign ram_wren       = wr_d2;
    assign ram_wr_address = col_d2;
    assign ram1_data      = pix_d2;
    assign ram2_data      = ram1_q;

    // ---------------- output stage ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_vs   <= 1'b0;
            out_de   <= 1'b0;
            out_row0 <= '0;
            out_row1 <= '0;
            out_row2 <= '0;
        end else begin
            out_vs   <= vs_d2;
            out_de   <= de_d2;
            out_row0 <= de_d2 ? pix_d2 : '0;
            out_row1 <= v1_d2 ? ram1_q : '0;
            out_row2 <= v2_d2 ? ram2_q : '0;
        end
    end

endmodule

// File: tb/tb_matrix_line_ctrl.sv
module tb_matrix_line_ctrl;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << (ADDR_W + 1);

    typedef struct packed {
        logic [DATA_W:0] r0;
        logic [DATA_W:0] r1;
        logic [DATA_W:0] r2;
    } exp_t;

    logic              clock;
    logic              reset;
    logic              in_vs;
    logic              in_de;
    logic [DATA_W:0]   in_data;
    logic              ram_rden;
    logic [ADDR_W:0]   ram_rd_address;
    logic              ram_wren;
    logic [ADDR_W:0]   ram_wr_address;
    logic [DATA_W:0]   ram1_data;
    logic [DATA_W:0]   ram2_data;
    logic [DATA_W:0]   ram1_q;
    logic [DATA_W:0]   ram2_q;
    logic              out_vs;
    logic              out_de;
    logic [DATA_W:0]   out_row0;
    logic [DATA_W:0]   out_row1;
    logic [DATA_W:0]   out_row2;
    logic              col_ovf;

    matrix_line_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_vs          (in_vs),
        .in_de          (in_de),
        .in_data        (in_data),
        .ram_rden       (ram_rden),
        .ram_rd_address (ram_rd_address),
        .ram_wren       (ram_wren),
        .ram_wr_address (ram_wr_address),
        .ram1_data      (ram1_data),
        .ram2_data      (ram2_data),
        .ram1_q         (ram1_q),
        .ram2_q         (ram2_q),
        .out_vs         (out_vs),
        .out_de         (out_de),
        .out_row0       (out_row0),
        .out_row1       (out_row1),
        .out_row2       (out_row2),
        .col_ovf        (col_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- line-buffer RAM models (2-cycle read, new data on conflict)
    logic [DATA_W:0] mem1 [DEPTH];
    logic [DATA_W:0] mem2 [DEPTH];
    logic [DATA_W:0] r1, r2, q1, q2;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem1[i] = '0;
            mem2[i] = '0;
        end
        r1 = '0; r2 = '0; q1 = '0; q2 = '0;
    end

    always @(posedge clock) begin
        if (ram_rden) begin
            r1 <= (ram_wren && ram_wr_address == ram_rd_address) ? ram1_data : mem1[ram_rd_address];
            r2 <= (ram_wren && ram_wr_address == ram_rd_address) ? ram2_data : mem2[ram_rd_address];
        end
        q1 <= r1;
        q2 <= r2;
        if (ram_wren) begin
            mem1[ram_wr_address] <= ram1_data;
            mem2[ram_wr_address] <= ram2_data;
        end
    end

    assign ram1_q = q1;
    assign ram2_q = q2;

    // ---------------- scoreboard / bookkeeping
    exp_t            sb [$];
    int              n_cmp = 0;
    int              n_bad = 0;
    logic            armed = 1'b0;
    logic            chk_conflict = 1'b0;
    int              lc = 0;
    logic            ovf_m = 1'b0;
    logic [DATA_W:0] m1 [DEPTH];
    logic [DATA_W:0] m2 [DEPTH];
    logic [2:0]      de_hist;
    logic [2:0]      vs_hist;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m1[i] = '0;
            m2[i] = '0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            de_hist <= '0;
            vs_hist <= '0;
        end else begin
            de_hist <= {de_hist[1:0], in_de & armed};
            vs_hist <= {vs_hist[1:0], in_vs};
        end
    end

    // ---------------- monitor
    always @(negedge clock) begin : monitor
        exp_t e;
        check("out_de_latency", out_de, de_hist[2]);
        check("out_vs_latency", out_vs, vs_hist[2]);
        if (out_de) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow: actual=out_de high required=queued entry (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                check("out_row0", out_row0, e.r0);
                check("out_row1", out_row1, e.r1);
                check("out_row2", out_row2, e.r2);
            end
        end else begin
            check("idle_taps", {out_row0, out_row1, out_row2}, '0);
        end
        if (chk_conflict && ram_wren && ram_rden) begin
            check("rw_same_addr", ram_wr_address == ram_rd_address, 0);
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [DATA_W:0] pix(input int row, input int c);
        logic [DATA_W:0] v;
        v = (DATA_W + 1)'(16 * row + c);
        return v;
    endfunction

    task automatic check_reset_outputs();
        check("rst_ram_rden",  ram_rden, 0);
        check("rst_rd_addr",   ram_rd_address, 0);
        check("rst_ram_wren",  ram_wren, 0);
        check("rst_wr_addr",   ram_wr_address, 0);
        check("rst_ram1_data", ram1_data, 0);
        check("rst_out_vs",    out_vs, 0);
        check("rst_out_de",    out_de, 0);
        check("rst_out_rows",  {out_row0, out_row1, out_row2}, 0);
        check("rst_col_ovf",   col_ovf, 0);
    endtask

    task automatic send_vs();
        in_vs = 1'b1;
        in_de = 1'b0;
        tick();
        in_vs = 1'b0;
        armed = 1'b1;
        lc    = 0;
        ovf_m = 1'b0;
        check("col_ovf_after_vs", col_ovf, 0);
    endtask

    // vs_at >= 0 raises in_vs together with that pixel and ends the line there.
    task automatic send_line(input int width, input int row, input int gap, input int vs_at);
        exp_t            e;
        logic [DATA_W:0] p;
        logic            in_rng;
        int              idx;
        for (int c = 0; c < width; c++) begin
            p       = pix(row, c);
            in_de   = 1'b1;
            in_data = p;
            in_vs   = (c == vs_at);
            #1;
            check("ram_rden", ram_rden, armed);
            if (armed) begin
                check("ram_rd_address", ram_rd_address, (c < DEPTH) ? c : DEPTH - 1);
                in_rng = (c < DEPTH);
                idx    = in_rng ? c : 0;
                e.r0   = p;
                e.r1   = (lc >= 1 && in_rng) ? m1[idx] : '0;
                e.r2   = (lc >= 2 && in_rng) ? m2[idx] : '0;
                sb.push_back(e);
                if (in_rng) begin
                    m2[idx] = m1[idx];
                    m1[idx] = p;
                end
                if (c == vs_at) ovf_m = 1'b0;
                else if (!in_rng) ovf_m = 1'b1;
            end
            tick();
            check("col_ovf", col_ovf, ovf_m);
            if (c == vs_at) break;
        end
        in_de   = 1'b0;
        in_vs   = 1'b0;
        in_data = '0;
        if (armed) begin
            if (vs_at >= 0 && vs_at < width) lc = 0;
            else lc = (lc < 2) ? lc + 1 : 2;
        end
        repeat (gap) tick();
    endtask

    // ---------------- directed sequence
    initial begin
        reset   = 1'b1;
        in_vs   = 1'b0;
        in_de   = 1'b0;
        in_data = '0;
        repeat (2) tick();
        check_reset_outputs();
        reset = 1'b0;
        tick();

        // 1: first frame, three lines of width 8
        send_vs();
        send_line(8, 0, 3, -1);
        send_line(8, 1, 3, -1);
        send_line(8, 2, 3, -1);
        repeat (4) tick();

        // 2: second frame, stale RAM contents must be masked
        send_vs();
        send_line(8, 3, 3, -1);
        send_line(8, 4, 3, -1);
        send_line(8, 5, 3, -1);
        repeat (4) tick();

        // 3: width 4 with single-cycle blanking, no same-address access
        send_vs();
        chk_conflict = 1'b1;
        for (int r = 6; r < 11; r++) begin
            send_line(4, r, 1, -1);
        end
        repeat (4) tick();
        chk_conflict = 1'b0;

        // 4: line longer than RAM depth
        send_vs();
        send_line(10, 11, 3, -1);
        check("col_ovf_sticky", col_ovf, 1);
        send_line(6, 12, 3, -1);
        check("col_ovf_still_set", col_ovf, 1);
        send_vs();

        // 5: frame start in the middle of line 2
        send_line(8, 13, 3, -1);
        send_line(8, 14, 3, -1);
        send_line(8, 15, 3, 3);
        send_line(8, 16, 3, -1);
        repeat (4) tick();

        // 6: reset pulsed mid-line, then ignored until the next frame start
        send_line(3, 17, 0, -1);
        in_de   = 1'b1;
        in_data = pix(17, 3);
        reset   = 1'b1;
        armed   = 1'b0;
        #1;
        check_reset_outputs();
        tick();
        check_reset_outputs();
        tick();
        check_reset_outputs();
        reset = 1'b0;
        in_de = 1'b0;
        sb.delete();
        lc    = 0;
        ovf_m = 1'b0;
        tick();
        send_line(8, 18, 3, -1);
        check("idle_no_output", out_de, 0);
        send_vs();
        send_line(8, 19, 3, -1);
        send_line(8, 20, 3, -1);
        send_line(8, 21, 3, -1);
        repeat (8) tick();

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
